// File: rtl/shift_cmd_queue.sv
// Rotate-command FIFO feeding a combinational barrel shifter, with a registered result stage.
// One cycle from accept to out_valid; in_ready drops only when the FIFO is full, and a stalled result holds the FIFO head.

module shift_cmd_fifo #(
    parameter int W     = 12,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdat,
    output logic [W-1:0]  rdat,
    output logic [AW:0]   count
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    // Head is read from the pre-write array, so an empty FIFO never forwards wdat.
    assign rdat  = mem_q[rd_ptr_q];
    assign count = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = wdat;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

module shift_cmd_queue #(
    parameter int N     = 32,
    parameter int M     = 5,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_num,
    input  logic [M-1:0]  in_amt,
    input  logic          in_lr,
    output logic [N-1:0]  sh_num,
    output logic [M-1:0]  sh_amt,
    output logic          sh_lr,
    input  logic [N-1:0]  sh_out,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_data,
    output logic [AW:0]   count
);
    typedef struct packed {
        logic [N-1:0] num;
        logic [M-1:0] amt;
        logic         lr;
    } cmd_t;

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    cmd_t         wr_cmd;
    cmd_t         head_cmd;
    logic         push_vld;
    logic         issue_vld;
    logic         out_valid_q, out_valid_d;
    logic [N-1:0] out_data_q, out_data_d;

    assign wr_cmd    = '{num: in_num, amt: in_amt, lr: in_lr};
    // Full check uses registered count only: no full-bypass and no out_ready->in_ready path.
    assign in_ready  = (count != FULL);
    assign push_vld  = in_valid && in_ready;
    assign issue_vld = (count != '0) && (!out_valid_q || out_ready);

    shift_cmd_fifo #(
        .W     ($bits(cmd_t)),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_vld),
        .pop   (issue_vld),
        .wdat  (wr_cmd),
        .rdat  (head_cmd),
        .count (count)
    );

    assign sh_num    = head_cmd.num;
    assign sh_amt    = head_cmd.amt;
    assign sh_lr     = head_cmd.lr;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (issue_vld) begin
            out_valid_d = 1'b1;
            out_data_d  = sh_out;
        end else if (out_ready) begin
            // Consumer took the last result and nothing is queued behind it.
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end
endmodule

// File: doc/shift_cmd_queue.md
Name: shift_cmd_queue

Overview:
- Command queue and result register that sits directly upstream and downstream of the multifunction barrel shifter.
- Buffers rotate requests {num, amt, LR} from a producer in a small FIFO.
- Presents the head entry to the shifter's num/amt/LR inputs and registers the shifter output.
- Returns the registered result to a consumer through a valid/ready handshake, so the combinational shifter becomes a 1-result-per-cycle pipelined unit.

Parameters:
- N, 32, data width; must match the attached shifter (8, 16 or 32).
- M, 5, shift-amount width; log2(N).
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- AW, 2, FIFO pointer width; log2(DEPTH).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer has a command.
- in_ready  output  1  queue can accept a command.
- in_num  input  N  operand to rotate.
- in_amt  input  M  rotate amount.
- in_lr  input  1  direction: 1 = left, 0 = right.
- sh_num  output  N  to shifter num.
- sh_amt  output  M  to shifter amt.
- sh_lr  output  1  to shifter LR.
- sh_out  input  N  from shifter out; combinational function of sh_*.
- out_valid  output  1  result register holds a result.
- out_ready  input  1  consumer accepts the result.
- out_data  output  N  registered rotate result.
- count  output  AW+1  FIFO occupancy, 0..DEPTH.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n; asserting it clears all state immediately, with no clock required.
- Reset values:
  - FIFO pointers 0, count 0, in_ready 1.
  - out_valid 0, out_data 0.
  - sh_num/sh_amt/sh_lr show entry 0 contents; their value is don't-care while the FIFO is empty. FIFO storage itself is not reset.
- Push: occurs on an edge where in_valid && in_ready.
  - in_ready = (count != DEPTH). It is not raised by a same-cycle pop, so there is no full-bypass.
  - Writes {in_num, in_amt, in_lr} at the write pointer.
  - The write pointer wraps modulo DEPTH.
- Head: sh_num/sh_amt/sh_lr are driven combinationally from the entry at the read pointer (read-before-write FIFO array).
- Issue: on the edge where (count != 0) && (!out_valid || out_ready):
  - out_data <= sh_out, out_valid <= 1;
  - the read pointer advances and wraps modulo DEPTH.
- Drain without issue: if out_valid && out_ready and count == 0, then out_valid <= 0 and out_data holds.
- Stall: if out_valid && !out_ready, out_data and out_valid hold and the FIFO does not pop.
- Count:
  - +1 on push only, -1 on issue only.
  - Unchanged on simultaneous push and issue, or when neither occurs.
  - Never exceeds DEPTH, never goes below 0.
- Latency: a command accepted at edge k, with an empty FIFO and out_valid low, produces out_valid at edge k+1. Sustained throughput is one result per cycle while out_ready stays high.
- Ordering: strict FIFO; results leave in acceptance order.
- No bypass: the empty FIFO never forwards in_* directly to the shifter.
- Width rules:
  - in_amt is passed through unmodified.
  - amt == 0 yields out_data == in_num.
  - amt values up to N-1 are legal; M bits cannot exceed N-1.
- Reset mid-operation: all queued commands and any pending result are discarded. out_valid drops asynchronously. in_ready is 1 after reset deasserts.
- No combinational path exists from out_ready to in_ready.

Test Plan:
- Reset and single command: N=8, M=3. Hold rst_n low, check in_ready=1, out_valid=0, count=0, out_data=0. Release, push num=8'h81, amt=1, lr=1 at edge k → out_valid=1 at k+1, out_data=8'h03, count=0.
- Right rotate and amount 0: push 8'hA5 amt=4 lr=0, then 8'h3C amt=0 lr=1, out_ready=1 → results 8'h5A then 8'h3C on consecutive cycles.
- Fill and backpressure: out_ready=0, push 5 commands with DEPTH=4.
  - Expect 4 into the FIFO plus 1 captured in the result register; count reaches 4 with in_ready=0.
  - Release out_ready → 5 results in order, one per cycle. count returns to 0 and in_ready returns to 1.
- Simultaneous push and issue at count=2 with out_valid=1, out_ready=1 → count stays 2 and the next result is the head entry. Read/write pointer wrap is exercised over 10 back-to-back commands with no loss or reordering.
- Stall hold: out_valid=1 with out_ready=0 for 3 cycles → out_data stable and count unchanged, with in_valid=0.
- Async reset mid-stream: 3 queued plus 1 pending result, pulse rst_n low between edges → out_valid=0 and count=0 immediately. The next pushed command emerges as the first result.
